lsu_mem_arbiter: RTL and testbench
==================================

// Module: lsu_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between LDQ load issue and STQ committed-store drain.
//  Sits between the load/store queues and data memory.
//  - Arbitrates with load priority plus a store anti-starvation limit.
//  - Sequences one outstanding memory transaction at a time.
//  - Reports completions back as load_executed / store_succeeded with the ROB tag.
// PARAMETERS
//  XLEN           32  address/data width
//  ROB_TAG_WIDTH  5   ROB tag width
//  STARVE_LIMIT   4   consecutive load grants while a store waits before the store is forced (>=1)
// PORTS
//  clk                      in   1              clock, rising edge
//  reset                    in   1              asynchronous, active-low
//  ld_req_valid             in   1              LDQ has an address-valid, unexecuted load
//  ld_req_addr              in   XLEN           load address
//  ld_req_tag               in   ROB_TAG_WIDTH  load ROB tag
//  ld_req_ready             out  1              load accepted this cycle (1-cycle pulse)
//  st_req_valid             in   1              STQ head is committed, with address and data valid
//  st_req_addr              in   XLEN           store address
//  st_req_data              in   XLEN           store data
//  st_req_tag               in   ROB_TAG_WIDTH  store ROB tag
//  st_req_ready             out  1              store accepted this cycle (1-cycle pulse)
//  mem_req_valid            out  1              memory request valid
//  mem_req_we               out  1              1=write, 0=read
//  mem_req_addr             out  XLEN           memory address
//  mem_req_wdata            out  XLEN           write data
//  mem_req_ready            in   1              memory accepts request
//  mem_resp_valid           in   1              read data valid / write ack
//  mem_resp_rdata           in   XLEN           read data
//  load_executed            out  1              load completion pulse
//  load_executed_rob_tag    out  ROB_TAG_WIDTH  completed load tag
//  load_data                out  XLEN           completed load data
//  store_succeeded          out  1              store completion pulse
//  store_succeeded_rob_tag  out  ROB_TAG_WIDTH  completed store tag
//  flush                    in   1              only with LSU_ARB_FLUSH_EN
// BEHAVIOUR
//  Reset:
//  - All outputs 0, FSM=IDLE, starve counter=0.
//  - Reset mid-transaction abandons it with no completion pulse.
//  FSM IDLE -> REQ -> RESP -> IDLE:
//  - IDLE: arbitrate.
//    - Grant goes to the store if st_req_valid && (!ld_req_valid || starve>=STARVE_LIMIT).
//    - Otherwise the load is granted if ld_req_valid.
//    - ld_req_ready / st_req_ready are combinational 1-cycle grant pulses, mutually exclusive.
//    - Addr, data, tag and type are latched; next state REQ.
//  - REQ: mem_req_* driven from latched regs, mem_req_valid=1.
//    - Held stable until mem_req_ready; then RESP.
//  - RESP: wait for mem_resp_valid; responses outside RESP are ignored.
//    - On the response, the next cycle pulses exactly one completion output and the FSM returns to IDLE.
//    - load_data = mem_resp_rdata captured on the response cycle.
//  Latency:
//  - Min grant->completion pulse = 3 cycles (ready and response both immediate).
//  - A new grant may occur in the completion-pulse cycle.
//  Starve counter:
//  - Increments on each load grant while st_req_valid is 1.
//  - Saturates at STARVE_LIMIT.
//  - Cleared on store grant, or on any IDLE cycle with st_req_valid=0.
//  Completion tags:
//  - Outputs hold their last values when the completion pulse is 0.
// CONFIGURATION
//  LSU_ARB_FLUSH_EN defined:
//  - flush=1 blocks load grants that cycle.
//  - A load in REQ/RESP still completes at memory, but its load_executed is suppressed.
//  - Stores are unaffected.
//  LSU_ARB_FLUSH_EN undefined:
//  - No flush port; every accepted load reports load_executed.
// TESTING
//  1. Load 0x100 tag 3, mem ready+resp immediate, rdata 0xDEADBEEF
//     -> ld_req_ready cycle0, load_executed cycle3, tag 3, data 0xDEADBEEF.
//  2. Store 0x200 data 0x55 tag 7
//     -> mem_req_we=1, wdata 0x55, store_succeeded tag 7 after ack.
//  3. ld_req_valid and st_req_valid continuously high, STARVE_LIMIT=4
//     -> 4 load grants then 1 store grant, repeating.
//  4. mem_req_ready low 5 cycles
//     -> mem_req_valid/addr stable all 5 cycles, no new grant.
//  5. reset low during RESP
//     -> outputs 0, no completion pulse, IDLE after release.
//  6. FLUSH_EN: flush during load RESP, tag 2
//     -> no load_executed; next store completes normally.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
// Handshake bundle between the load/store queues, the data-memory port and the
// LSU memory arbiter; the arbiter uses the master view, the environment the slave view.
interface lsu_mem_arbiter_if #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 5
);
    logic                     ld_req_valid;
    logic [XLEN-1:0]          ld_req_addr;
    logic [ROB_TAG_WIDTH-1:0] ld_req_tag;
    logic                     ld_req_ready;

    logic                     st_req_valid;
    logic [XLEN-1:0]          st_req_addr;
    logic [XLEN-1:0]          st_req_data;
    logic [ROB_TAG_WIDTH-1:0] st_req_tag;
    logic                     st_req_ready;

    logic                     mem_req_valid;
    logic                     mem_req_we;
    logic [XLEN-1:0]          mem_req_addr;
    logic [XLEN-1:0]          mem_req_wdata;
    logic                     mem_req_ready;
    logic                     mem_resp_valid;
    logic [XLEN-1:0]          mem_resp_rdata;

    logic                     load_executed;
    logic [ROB_TAG_WIDTH-1:0] load_executed_rob_tag;
    logic [XLEN-1:0]          load_data;
    logic                     store_succeeded;
    logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag;

    modport master (
        input  ld_req_valid, ld_req_addr, ld_req_tag,
        output ld_req_ready,
        input  st_req_valid, st_req_addr, st_req_data, st_req_tag,
        output st_req_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output load_executed, load_executed_rob_tag, load_data,
        output store_succeeded, store_succeeded_rob_tag
    );

    modport slave (
        output ld_req_valid, ld_req_addr, ld_req_tag,
        input  ld_req_ready,
        output st_req_valid, st_req_addr, st_req_data, st_req_tag,
        input  st_req_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  load_executed, load_executed_rob_tag, load_data,
        input  store_succeeded, store_succeeded_rob_tag
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port between LDQ load issue and STQ store drain, one transaction
// at a time, load priority with a store anti-starvation limit. Optional: LSU_ARB_FLUSH_EN.
module lsu_mem_arbiter #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 5,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef LSU_ARB_FLUSH_EN
    input  logic              flush,
`endif
    lsu_mem_arbiter_if.master bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                   state_q;
    logic [CW-1:0]            starve_q, starve_d;
    logic                     req_valid_q, we_q, kill_q;
    logic [XLEN-1:0]          addr_q, wdata_q, ld_data_q;
    logic [ROB_TAG_WIDTH-1:0] tag_q, ld_tag_q, st_tag_q;
    logic                     ld_exec_q, st_succ_q;
    logic                     flush_w, ld_cand, ld_grant, st_grant;

`ifdef LSU_ARB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // A flushed cycle looks to the arbiter as if no load were pending.
    assign ld_cand  = bus.ld_req_valid && !flush_w;
    assign st_grant = (state_q == IDLE) && bus.st_req_valid && (!ld_cand || starve_q >= LIMIT);
    assign ld_grant = (state_q == IDLE) && ld_cand && !st_grant;

    // NOTE: every always_comb target gets a default first so no latch can be inferred.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (st_grant || !bus.st_req_valid) starve_d = '0;
            else if (ld_grant && starve_q < LIMIT) starve_d = starve_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            kill_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag_q       <= '0;
            ld_exec_q   <= 1'b0;
            ld_tag_q    <= '0;
            ld_data_q   <= '0;
            st_succ_q   <= 1'b0;
            st_tag_q    <= '0;
        end else begin
            starve_q  <= starve_d;
            ld_exec_q <= 1'b0;
            st_succ_q <= 1'b0;
            if (state_q != IDLE && !we_q && flush_w) kill_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (st_grant || ld_grant) begin
                        we_q        <= st_grant;
                        addr_q      <= st_grant ? bus.st_req_addr : bus.ld_req_addr;
                        wdata_q     <= st_grant ? bus.st_req_data : '0;
                        tag_q       <= st_grant ? bus.st_req_tag  : bus.ld_req_tag;
                        req_valid_q <= 1'b1;
                        kill_q      <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        state_q <= IDLE;
                        if (we_q) begin
                            st_succ_q <= 1'b1;
                            st_tag_q  <= tag_q;
                        end else if (!(kill_q || flush_w)) begin
                            ld_exec_q <= 1'b1;
                            ld_tag_q  <= tag_q;
                            ld_data_q <= bus.mem_resp_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ld_req_ready            = ld_grant;
    assign bus.st_req_ready            = st_grant;
    assign bus.mem_req_valid           = req_valid_q;
    assign bus.mem_req_we              = we_q;
    assign bus.mem_req_addr            = addr_q;
    assign bus.mem_req_wdata           = wdata_q;
    assign bus.load_executed           = ld_exec_q;
    assign bus.load_executed_rob_tag   = ld_tag_q;
    assign bus.load_data               = ld_data_q;
    assign bus.store_succeeded         = st_succ_q;
    assign bus.store_succeeded_rob_tag = st_tag_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed self-checking bench for lsu_mem_arbiter with a small delay-programmable memory
// responder; the flush scenario is compiled in only with LSU_ARB_FLUSH_EN.
module tb_lsu_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
`ifdef LSU_ARB_FLUSH_EN
    logic flush = 1'b0;
`endif
    int compared = 0;
    int mismatched = 0;

    int          ready_delay = 0;
    int          resp_delay = 0;
    logic [31:0] resp_data = '0;
    int          wait_cnt = 0;
    int          resp_cnt = -1;

    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.XLEN(32), .ROB_TAG_WIDTH(5)) bus ();

    lsu_mem_arbiter #(.XLEN(32), .ROB_TAG_WIDTH(5), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef LSU_ARB_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    // Memory model: ready after ready_delay waiting cycles, response resp_delay cycles after handshake.
    always @(posedge clk) begin
        #1;
        bus.mem_resp_valid = 1'b0;
        if (resp_cnt == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = resp_data;
            resp_cnt = -1;
        end else if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
        end
        if (bus.mem_req_valid) begin
            if (wait_cnt >= ready_delay) begin
                bus.mem_req_ready = 1'b1;
                wait_cnt = 0;
                resp_cnt = resp_delay;
            end else begin
                bus.mem_req_ready = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            bus.mem_req_ready = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (bus.mem_req_valid !== 1'b0 || bus.load_executed !== 1'b0 || bus.store_succeeded !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_pulses: valid=%b lexec=%b ssucc=%b want 0 0 0", bus.mem_req_valid, bus.load_executed, bus.store_succeeded);
        end
        compared++;
        if (bus.mem_req_addr !== 32'h0 || bus.load_data !== 32'h0 || bus.load_executed_rob_tag !== 5'd0 || bus.store_succeeded_rob_tag !== 5'd0) begin
            mismatched++;
            $display("FAIL rst_regs: addr=%h ldata=%h ltag=%0d stag=%0d want all 0", bus.mem_req_addr, bus.load_data, bus.load_executed_rob_tag, bus.store_succeeded_rob_tag);
        end
        compared++;
        if (bus.ld_req_ready !== 1'b0 || bus.st_req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_ready: ld=%b st=%b want 0 0", bus.ld_req_ready, bus.st_req_ready);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_load();
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h100;
        bus.ld_req_tag   = 5'd3;
        resp_data        = 32'hDEADBEEF;
        #1;
        compared++;
        if (bus.ld_req_ready !== 1'b1 || bus.st_req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ld_grant: ld_ready=%b st_ready=%b want 1 0", bus.ld_req_ready, bus.st_req_ready);
        end
        step();
        bus.ld_req_valid = 1'b0;
        compared++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_we !== 1'b0 || bus.mem_req_addr !== 32'h100) begin
            mismatched++;
            $display("FAIL ld_req: valid=%b we=%b addr=%h want 1 0 00000100", bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr);
        end
        step();
        compared++;
        if (bus.mem_req_valid !== 1'b0 || bus.load_executed !== 1'b0) begin
            mismatched++;
            $display("FAIL ld_resp_wait: valid=%b lexec=%b want 0 0", bus.mem_req_valid, bus.load_executed);
        end
        step();
        compared++;
        if (bus.load_executed !== 1'b1 || bus.load_executed_rob_tag !== 5'd3 || bus.load_data !== 32'hDEADBEEF || bus.store_succeeded !== 1'b0) begin
            mismatched++;
            $display("FAIL ld_done: lexec=%b tag=%0d data=%h ssucc=%b want 1 3 deadbeef 0", bus.load_executed, bus.load_executed_rob_tag, bus.load_data, bus.store_succeeded);
        end
        step();
        compared++;
        if (bus.load_executed !== 1'b0 || bus.load_executed_rob_tag !== 5'd3 || bus.load_data !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL ld_hold: lexec=%b tag=%0d data=%h want 0 3 deadbeef", bus.load_executed, bus.load_executed_rob_tag, bus.load_data);
        end
    endtask

    task automatic test_store();
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h200;
        bus.st_req_data  = 32'h55;
        bus.st_req_tag   = 5'd7;
        #1;
        compared++;
        if (bus.st_req_ready !== 1'b1 || bus.ld_req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL st_grant: st_ready=%b ld_ready=%b want 1 0", bus.st_req_ready, bus.ld_req_ready);
        end
        step();
        bus.st_req_valid = 1'b0;
        compared++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_we !== 1'b1 || bus.mem_req_addr !== 32'h200 || bus.mem_req_wdata !== 32'h55) begin
            mismatched++;
            $display("FAIL st_req: valid=%b we=%b addr=%h wdata=%h want 1 1 00000200 00000055", bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata);
        end
        step();
        step();
        compared++;
        if (bus.store_succeeded !== 1'b1 || bus.store_succeeded_rob_tag !== 5'd7 || bus.load_executed !== 1'b0) begin
            mismatched++;
            $display("FAIL st_done: ssucc=%b tag=%0d lexec=%b want 1 7 0", bus.store_succeeded, bus.store_succeeded_rob_tag, bus.load_executed);
        end
    endtask

    task automatic test_starvation();
        int   grants = 0;
        int   last_cyc = 0;
        logic exp_st;
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h700;
        bus.ld_req_tag   = 5'd1;
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h800;
        bus.st_req_data  = 32'hAA;
        bus.st_req_tag   = 5'd9;
        for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            #1;
            if (bus.ld_req_ready || bus.st_req_ready) begin
                exp_st = ((grants % 5) == 4) ? 1'b1 : 1'b0;
                compared++;
                if (bus.st_req_ready !== exp_st || bus.ld_req_ready !== ~exp_st) begin
                    mismatched++;
                    $display("FAIL starve_grant%0d: st=%b ld=%b want st=%b", grants, bus.st_req_ready, bus.ld_req_ready, exp_st);
                end
                if (grants > 0) begin
                    compared++;
                    if (cyc - last_cyc != 3) begin
                        mismatched++;
                        $display("FAIL b2b_spacing%0d: %0d cycles want 3", grants, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                grants++;
            end
            step();
        end
        compared++;
        if (grants != 10) begin
            mismatched++;
            $display("FAIL starve_count: %0d grants want 10", grants);
        end
        bus.ld_req_valid = 1'b0;
        bus.st_req_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_ready_stall();
        ready_delay      = 5;
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h300;
        bus.ld_req_tag   = 5'd4;
        bus.st_req_valid = 1'b1;
        resp_data        = 32'hCAFE0004;
        #1;
        compared++;
        if (bus.ld_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_grant: ld_ready=%b want 1", bus.ld_req_ready);
        end
        step();
        bus.ld_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            compared++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h300 || bus.ld_req_ready !== 1'b0 || bus.st_req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_hold%0d: valid=%b addr=%h ld=%b st=%b want 1 00000300 0 0", k, bus.mem_req_valid, bus.mem_req_addr, bus.ld_req_ready, bus.st_req_ready);
            end
            step();
        end
        bus.st_req_valid = 1'b0;
        step();
        step();
        compared++;
        if (bus.load_executed !== 1'b1 || bus.load_executed_rob_tag !== 5'd4 || bus.load_data !== 32'hCAFE0004) begin
            mismatched++;
            $display("FAIL stall_done: lexec=%b tag=%0d data=%h want 1 4 cafe0004", bus.load_executed, bus.load_executed_rob_tag, bus.load_data);
        end
        ready_delay = 0;
        step();
    endtask

    task automatic test_reset_in_resp();
        int pulses = 0;
        resp_delay       = 3;
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h400;
        bus.ld_req_tag   = 5'd6;
        resp_data        = 32'h0BAD0BAD;
        #1;
        compared++;
        if (bus.ld_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rr_grant: ld_ready=%b want 1", bus.ld_req_ready);
        end
        step();
        bus.ld_req_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        compared++;
        if (bus.mem_req_valid !== 1'b0 || bus.load_executed !== 1'b0 || bus.load_executed_rob_tag !== 5'd0 || bus.load_data !== 32'h0 || bus.mem_req_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL rr_outputs: valid=%b lexec=%b tag=%0d data=%h addr=%h want all 0", bus.mem_req_valid, bus.load_executed, bus.load_executed_rob_tag, bus.load_data, bus.mem_req_addr);
        end
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.load_executed !== 1'b0 || bus.mem_req_valid !== 1'b0) pulses++;
        end
        compared++;
        if (pulses != 0) begin
            mismatched++;
            $display("FAIL rr_no_pulse: %0d active cycles want 0", pulses);
        end
        resp_delay       = 0;
        resp_data        = 32'h12345678;
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h500;
        bus.ld_req_tag   = 5'd10;
        #1;
        compared++;
        if (bus.ld_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rr_idle_grant: ld_ready=%b want 1", bus.ld_req_ready);
        end
        step();
        bus.ld_req_valid = 1'b0;
        step();
        step();
        compared++;
        if (bus.load_executed !== 1'b1 || bus.load_executed_rob_tag !== 5'd10 || bus.load_data !== 32'h12345678) begin
            mismatched++;
            $display("FAIL rr_recover: lexec=%b tag=%0d data=%h want 1 10 12345678", bus.load_executed, bus.load_executed_rob_tag, bus.load_data);
        end
        step();
    endtask

`ifdef LSU_ARB_FLUSH_EN
    task automatic test_flush();
        flush            = 1'b1;
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h600;
        bus.ld_req_tag   = 5'd2;
        resp_data        = 32'hFEEDF00D;
        #1;
        compared++;
        if (bus.ld_req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL fl_block: ld_ready=%b want 0", bus.ld_req_ready);
        end
        step();
        flush      = 1'b0;
        resp_delay = 1;
        #1;
        compared++;
        if (bus.ld_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL fl_grant: ld_ready=%b want 1", bus.ld_req_ready);
        end
        step();
        bus.ld_req_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        compared++;
        if (bus.load_executed !== 1'b0 || bus.load_executed_rob_tag !== 5'd10) begin
            mismatched++;
            $display("FAIL fl_suppress: lexec=%b tag=%0d want 0 10", bus.load_executed, bus.load_executed_rob_tag);
        end
        step();
        resp_delay       = 0;
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h900;
        bus.st_req_data  = 32'h66;
        bus.st_req_tag   = 5'd8;
        #1;
        compared++;
        if (bus.st_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL fl_st_grant: st_ready=%b want 1", bus.st_req_ready);
        end
        step();
        bus.st_req_valid = 1'b0;
        step();
        step();
        compared++;
        if (bus.store_succeeded !== 1'b1 || bus.store_succeeded_rob_tag !== 5'd8) begin
            mismatched++;
            $display("FAIL fl_st_done: ssucc=%b tag=%0d want 1 8", bus.store_succeeded, bus.store_succeeded_rob_tag);
        end
        step();
    endtask
`endif

    initial begin
        bus.ld_req_valid   = 1'b0;
        bus.ld_req_addr    = '0;
        bus.ld_req_tag     = '0;
        bus.st_req_valid   = 1'b0;
        bus.st_req_addr    = '0;
        bus.st_req_data    = '0;
        bus.st_req_tag     = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        test_reset();
        test_load();
        test_store();
        test_starvation();
        test_ready_stall();
        test_reset_in_resp();
`ifdef LSU_ARB_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
